ternary_weight_streamer: RTL and testbench

Upstream weight-supply stage for `ternary_matmul`. On a start command it issues in-order DDR word reads from a start address and buffers the returned words in a small FIFO. It never issues more reads than it has buffer space for. Each buffered word is unpacked into signed ternary weights and presented on a valid/ready stream for the matmul datapath to consume.

---
 rtl/config_pkg.sv | 27 ++
 rtl/weight_fifo.sv | 65 ++++++
 rtl/ternary_weight_streamer.sv | 162 ++++++++++++++++
 tb/tb_ternary_weight_streamer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/config_pkg.sv
// Shared types for the DDR-fed ternary matmul path.
// Word/address types plus ternary weight encoding.
package config_pkg;

    typedef logic [31:0] ddr_address_t;
    typedef logic [31:0] ddr_data_t;

    typedef logic signed [1:0] trit_t;

    localparam int TRITS_PER_WORD = $bits(ddr_data_t) / 2;

    localparam logic [1:0] TRIT_ZERO    = 2'b00;
    localparam logic [1:0] TRIT_POS     = 2'b01;
    localparam logic [1:0] TRIT_NEG     = 2'b11;
    localparam logic [1:0] TRIT_ILLEGAL = 2'b10;

    function automatic trit_t decode_trit(input logic [1:0] code);
        trit_t t;
        case (code)
            TRIT_POS: t = 2'sb01;
            TRIT_NEG: t = 2'sb11;
            default:  t = 2'sb00;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/weight_fifo.sv
// Synchronous FIFO for buffered DDR words.
// Head is read straight out of the storage registers.
module weight_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;

    assign head = mem[rd_ptr];

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 1'b1;
        end else if (pop && !push) begin
            count_nxt = count - 1'b1;
        end
    end

    // Storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and registered full/empty flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/ternary_weight_streamer.sv
// Fetches a run of DDR words under a credit limit and
// streams them out as decoded ternary weight beats.
import config_pkg::*;

module ternary_weight_streamer #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  ddr_address_t start_addr_i,
    input  logic [15:0]  num_words_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         illegal_o,
    output ddr_address_t ddr_address_o,
    output logic         ddr_r_en_o,
    input  ddr_data_t    ddr_r_data_i,
    input  logic         ddr_r_valid_i,
    output logic         w_valid_o,
    input  logic         w_ready_i,
    output trit_t        w_trits_o [TRITS_PER_WORD],
    output logic         w_last_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [15:0]  num_q;
    logic [15:0]  issued_q;
    logic [15:0]  emitted_q;
    logic [CW-1:0] credits_q;
    ddr_address_t addr_ptr_q;

    logic [15:0]  num_base;
    logic [15:0]  issued_base;
    logic [CW-1:0] credits_base;
    ddr_address_t addr_base;
    logic         run_next;
    logic         sched;

    logic         fifo_full;
    logic         fifo_empty;
    ddr_data_t    head;
    logic         head_illegal;
    logic         pop;
    logic         final_hs;
    logic         start_ok;

    weight_fifo #(
        .WIDTH($bits(ddr_data_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk_i),
        .rst  (rst_i),
        .push (ddr_r_valid_i),
        .wdata(ddr_r_data_i),
        .pop  (pop),
        .full (fifo_full),
        .empty(fifo_empty),
        .head (head)
    );

    assign w_valid_o = ~fifo_empty;
    assign pop       = w_valid_o & w_ready_i;
    assign w_last_o  = w_valid_o & (emitted_q == num_q - 16'd1);
    assign final_hs  = pop & w_last_o;
    assign start_ok  = (state == IDLE) & start_i;

    // Unpack the head word into signed weights.
    always_comb begin
        head_illegal = 1'b0;
        for (int i = 0; i < TRITS_PER_WORD; i++) begin
            w_trits_o[i] = decode_trit(head[2*i +: 2]);
            if (head[2*i +: 2] == TRIT_ILLEGAL) begin
                head_illegal = 1'b1;
            end
        end
    end

    // Next state and the read to present next cycle.
    // A credit is taken when a read is scheduled and
    // returned when its word is popped.
    always_comb begin
        num_base     = num_q;
        issued_base  = issued_q;
        credits_base = credits_q - CW'(pop);
        addr_base    = addr_ptr_q;
        run_next     = (state == RUN) && !final_hs;
        state_nxt    = state;
        unique case (1'b1)
            start_ok: begin
                num_base     = num_words_i;
                issued_base  = '0;
                credits_base = '0;
                addr_base    = start_addr_i;
                run_next     = (num_words_i != '0);
                state_nxt    = run_next ? RUN : DONE;
            end
            (state == RUN) && final_hs: state_nxt = DONE;
            (state == DONE):            state_nxt = IDLE;
            default: ;
        endcase
        sched = run_next
              && (issued_base < num_base)
              && (credits_base < CW'(FIFO_DEPTH));
    end

    // Control state, counters and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            illegal_o     <= 1'b0;
            ddr_r_en_o    <= 1'b0;
            ddr_address_o <= '0;
            addr_ptr_q    <= '0;
            num_q         <= '0;
            issued_q      <= '0;
            emitted_q     <= '0;
            credits_q     <= '0;
        end else begin
            state      <= state_nxt;
            busy_o     <= (state_nxt == RUN);
            done_o     <= (state_nxt == DONE);
            num_q      <= num_base;
            ddr_r_en_o <= sched;
            if (sched) begin
                ddr_address_o <= addr_base;
                addr_ptr_q    <= addr_base + ddr_address_t'(1);
                issued_q      <= issued_base + 16'd1;
                credits_q     <= credits_base + CW'(1);
            end else begin
                addr_ptr_q    <= addr_base;
                issued_q      <= issued_base;
                credits_q     <= credits_base;
            end
            if (start_ok) begin
                emitted_q <= '0;
                illegal_o <= 1'b0;
            end else if (pop) begin
                emitted_q <= emitted_q + 16'd1;
                if (head_illegal) begin
                    illegal_o <= 1'b1;
                end
            end
        end
    end

    // The credit limit must keep every return in bounds.
    assert property (@(posedge clk_i) disable iff (rst_i)
        !(ddr_r_valid_i && fifo_full));

endmodule

// File: tb/tb_ternary_weight_streamer.sv
// Bench for ternary_weight_streamer: DDR model with
// variable latency plus a beat-by-beat reference model.
import config_pkg::*;

module tb_ternary_weight_streamer;

    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         start_i;
    ddr_address_t start_addr_i;
    logic [15:0]  num_words_i;
    logic         busy_o;
    logic         done_o;
    logic         illegal_o;
    ddr_address_t ddr_address_o;
    logic         ddr_r_en_o;
    ddr_data_t    ddr_r_data_i;
    logic         ddr_r_valid_i;
    logic         w_valid_o;
    logic         w_ready_i;
    trit_t        w_trits [TRITS_PER_WORD];
    logic         w_last_o;

    ternary_weight_streamer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .start_addr_i (start_addr_i),
        .num_words_i  (num_words_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .illegal_o    (illegal_o),
        .ddr_address_o(ddr_address_o),
        .ddr_r_en_o   (ddr_r_en_o),
        .ddr_r_data_i (ddr_r_data_i),
        .ddr_r_valid_i(ddr_r_valid_i),
        .w_valid_o    (w_valid_o),
        .w_ready_i    (w_ready_i),
        .w_trits_o    (w_trits),
        .w_last_o     (w_last_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        ddr_data_t data;
        int        due;
    } ret_t;

    typedef struct {
        ddr_address_t addr;
        int  num;
        int  lat;
        bit  lat_rand;
        int  rmode;
        int  hold;
        bit  poke;
        bit  clean;
        int  exp_hold;
    } vec_t;

    ret_t ddrq [$];
    vec_t vecs [8];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int req_cnt, pop_cnt, exp_n;
    int first_req, last_req, first_pop, last_pop;
    int final_edge, last_due, hold_cnt, rmode, lat;
    bit lat_rand, clean, force_mode, exp_ill;
    ddr_address_t exp_start;
    logic [31:0] salt, force_word;

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h",
                     name, act, exp);
        end
    endtask

    function automatic ddr_data_t word_of(ddr_address_t a);
        ddr_data_t d;
        if (force_mode) return force_word;
        d = (a * 32'h9E3779B1) ^ salt;
        if (clean) begin
            for (int i = 0; i < TRITS_PER_WORD; i++)
                if (d[2*i +: 2] == 2'b10) d[2*i +: 2] = 2'b01;
        end
        return d;
    endfunction

    function automatic logic [31:0] exp_pack(ddr_data_t w);
        logic [31:0] p;
        int v;
        int code;
        p = '0;
        for (int i = 0; i < TRITS_PER_WORD; i++) begin
            code = int'(w[2*i +: 2]);
            v = (code == 1) ? 1 : (code == 3) ? -1 : 0;
            p[2*i +: 2] = v[1:0];
        end
        return p;
    endfunction

    function automatic bit any_illegal(ddr_data_t w);
        for (int i = 0; i < TRITS_PER_WORD; i++)
            if (w[2*i +: 2] == 2'b10) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] act_pack();
        logic [31:0] p;
        for (int i = 0; i < TRITS_PER_WORD; i++)
            p[2*i +: 2] = w_trits[i];
        return p;
    endfunction

    task automatic tick();
        int l;
        int due;
        ddr_data_t w;
        @(posedge clk);
        #1;
        cyc++;
        if (ddr_r_en_o) begin
            chk("rd_addr", ddr_address_o,
                ddr_address_t'(exp_start + req_cnt));
            chk("rd_count_bound", req_cnt < exp_n, 1);
            l = lat_rand ? int'($urandom_range(1, lat)) : lat;
            due = cyc + 1 + l;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            ddrq.push_back('{word_of(ddr_address_o), due});
            if (req_cnt == 0) first_req = cyc;
            last_req = cyc;
            req_cnt++;
            chk("inflight", (req_cnt - pop_cnt) <= DEPTH, 1);
        end
        if (ddrq.size() > 0 && ddrq[0].due == cyc + 1) begin
            ddr_r_valid_i = 1'b1;
            ddr_r_data_i = ddrq[0].data;
            void'(ddrq.pop_front());
        end else begin
            ddr_r_valid_i = 1'b0;
            ddr_r_data_i = $urandom;
        end
        if (hold_cnt > 0) begin
            hold_cnt--;
            w_ready_i = 1'b0;
        end else begin
            case (rmode)
                0: w_ready_i = 1'b0;
                1: w_ready_i = 1'b1;
                default: w_ready_i = 1'($urandom_range(0, 1));
            endcase
        end
        if (w_valid_o && w_ready_i) begin
            chk("beat_bound", pop_cnt < exp_n, 1);
            w = word_of(ddr_address_t'(exp_start + pop_cnt));
            chk("trits", act_pack(), exp_pack(w));
            chk("last", w_last_o, pop_cnt == exp_n - 1);
            if (any_illegal(w)) exp_ill = 1'b1;
            if (pop_cnt == 0) first_pop = cyc;
            last_pop = cyc;
            if (pop_cnt == exp_n - 1) final_edge = cyc + 1;
            pop_cnt++;
        end
    endtask

    task automatic setup(input vec_t v);
        exp_start = v.addr;
        exp_n = v.num;
        lat = v.lat;
        lat_rand = v.lat_rand;
        clean = v.clean;
        rmode = v.rmode;
        hold_cnt = v.hold;
        req_cnt = 0;
        pop_cnt = 0;
        exp_ill = 1'b0;
        first_req = -1;
        first_pop = -1;
        final_edge = -1;
        last_due = 0;
        salt = $urandom;
    endtask

    task automatic run_xfer(input vec_t v);
        bit poked = 0;
        bit hold_ck = 0;
        setup(v);
        if (v.num == 0) final_edge = cyc + 1;
        start_i = 1'b1;
        start_addr_i = v.addr;
        num_words_i = 16'(v.num);
        tick();
        start_i = 1'b0;
        start_addr_i = $urandom;
        num_words_i = 16'($urandom);
        chk("start_busy", busy_o, v.num != 0);
        chk("start_done", done_o, v.num == 0);
        chk("start_illegal_clr", illegal_o, 0);
        chk("start_rd_en", ddr_r_en_o, v.num != 0);
        if (v.num != 0) begin
            chk("first_rd_cycle", first_req, cyc);
            chk("first_rd_addr", ddr_address_o, v.addr);
        end
        for (int t = 0; t < 4000 && !done_o; t++) begin
            if (v.poke && !poked && busy_o && pop_cnt >= 2) begin
                start_i = 1'b1;
                start_addr_i = $urandom;
                num_words_i = 16'd5;
                poked = 1;
            end
            tick();
            start_i = 1'b0;
            if (v.hold > 0 && !hold_ck && hold_cnt == 0) begin
                hold_ck = 1;
                chk("reads_held", req_cnt, v.exp_hold);
                chk("rd_en_held", ddr_r_en_o, 0);
            end
        end
        chk("done_seen", done_o, 1);
        chk("done_cycle", cyc, final_edge);
        chk("busy_at_done", busy_o, 0);
        chk("reads_total", req_cnt, v.num);
        chk("beats_total", pop_cnt, v.num);
        chk("illegal_at_done", illegal_o, exp_ill);
        if (v.rmode == 1 && v.hold == 0 && !v.lat_rand
            && v.lat <= DEPTH - 2 && v.num > 0) begin
            chk("rd_back_to_back", last_req - first_req, v.num - 1);
            chk("beat_back_to_back", last_pop - first_pop, v.num - 1);
            chk("first_beat_latency", first_pop - first_req, 1 + v.lat);
        end
        tick();
        chk("done_pulse", done_o, 0);
        chk("idle_busy", busy_o, 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_illegal"}, illegal_o, 0);
        chk({tag, "_rd_en"}, ddr_r_en_o, 0);
        chk({tag, "_addr"}, ddr_address_o, 0);
        chk({tag, "_w_valid"}, w_valid_o, 0);
        chk({tag, "_w_last"}, w_last_o, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog cycles=%0d required=finish", cyc);
        $fatal(1);
    end

    initial begin
        vec_t rv;
        //         addr           num lat rnd rm hold pk cl exph
        vecs[0] = '{32'h0000_0100,  4, 3, 0, 1,  0, 0, 1, 0};
        vecs[1] = '{32'h0000_2000, 20, 2, 0, 1, 30, 0, 0, 8};
        vecs[2] = '{32'h0000_0040,  0, 2, 0, 1,  0, 0, 1, 0};
        vecs[3] = '{32'hFFFF_FFFF,  3, 1, 0, 1,  0, 0, 1, 0};
        vecs[4] = '{32'h0000_5555, 37, 5, 1, 2,  0, 1, 0, 0};
        vecs[5] = '{32'h0000_07F0, 16, 6, 0, 1,  0, 0, 1, 0};
        vecs[6] = '{32'h0000_0ABC, 64, 4, 1, 2, 10, 0, 1, 8};
        vecs[7] = '{32'h0000_0042,  1, 7, 0, 1,  0, 1, 0, 0};

        force_mode = 0;
        force_word = '0;
        exp_n = 0;
        exp_start = '0;
        rmode = 1;
        hold_cnt = 0;
        lat = 1;
        lat_rand = 0;
        clean = 1;
        last_due = 0;
        req_cnt = 0;
        pop_cnt = 0;
        rst_i = 1'b1;
        start_i = 1'b0;
        start_addr_i = '0;
        num_words_i = '0;
        ddr_r_valid_i = 1'b0;
        ddr_r_data_i = '0;
        w_ready_i = 1'b0;
        tick();
        tick();
        chk_reset("por");
        rst_i = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) run_xfer(vecs[i]);

        force_mode = 1;
        force_word = 32'h0000_00B4;
        run_xfer('{32'h0000_0900, 1, 2, 0, 1, 0, 0, 1, 0});
        chk("illegal_sticky", illegal_o, 1);
        force_mode = 0;
        run_xfer(vecs[0]);

        rv = '{32'h0000_0300, 10, 2, 0, 1, 0, 0, 0, 0};
        setup(rv);
        start_i = 1'b1;
        start_addr_i = rv.addr;
        num_words_i = 16'(rv.num);
        tick();
        start_i = 1'b0;
        for (int t = 0; t < 200 && pop_cnt < 3; t++) tick();
        chk("pre_rst_beats", pop_cnt >= 3, 1);
        rst_i = 1'b1;
        ddrq.delete();
        tick();
        rst_i = 1'b0;
        chk_reset("mid_rst");
        run_xfer(vecs[3]);
        run_xfer(vecs[4]);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
